mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage MIPS32 pipeline, placed between the EXE/MEM pipeline register and `MEM_WB_REG`. It issues load/store transactions on the request/ready data-SRAM bus and detects load/store address-alignment exceptions. It aligns and extends load data, then presents a 128-bit result bundle plus a 7-bit exception vector. `MEM_over` is raised only when that bundle is stable.

## Interface
Parameters: none (widths fixed by the MIPS32 datapath).

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `cancel`  in  1  flush from exception logic; drops the in-flight instruction
- `MEM_valid`  in  1  `MEM_IN` holds a live instruction
- `MEM_IN`  in  128  [127:96] IR, [95:64] PC4, [63:32] ALU result/address, [31:0] rt (store data)
- `MEM_IN_LO`  in  32  LO result, passed through
- `MEM_IN_EXC`  in  7  upstream exception bits, same encoding as `MEM_OUT_EXC`
- `MEM_IN_DELAY`  in  1  instruction is in a branch delay slot
- `WB_allow_in`  in  1  downstream register accepts this cycle
- `MEM_allow_in`  out  1  upstream may load a new instruction
- `MEM_over`  out  1  `MEM_OUT`/`MEM_OUT_EXC` valid and complete
- `MEM_OUT`  out  128  [127:96] IR, [95:64] PC4, [63:32] AO (load data, ALU result or BadVAddr), [31:0] LO
- `MEM_OUT_EXC`  out  7  [6] PC fetch, [5] load addr error, [4] store addr error, [3] syscall, [2] break, [1] reserved instr, [0] overflow
- `MEM_OUT_DELAY`  out  1  pass-through of `MEM_IN_DELAY`
- `data_req`  out  1  bus request
- `data_wr`  out  1  1 = store
- `data_size`  out  2  0 byte, 1 half, 2 word
- `data_addr`  out  32  byte address
- `data_wdata`  out  32  byte/half-replicated store data
- `data_addr_ok`  in  1  request accepted
- `data_data_ok`  in  1  read data valid / write complete
- `data_rdata`  in  32  read data

## Operation
- Decoding uses `IR[31:26]`:
  - Loads are LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores are SB 0x28, SH 0x29, SW 0x2B.
  - Every other opcode is non-memory.
- Address error:
  - Word accesses fault when `addr[1:0]` is not 0; half accesses fault when `addr[0]` is not 0.
  - A fault sets bit 5 (load) or bit 4 (store) in `MEM_OUT_EXC`, ORed with `MEM_IN_EXC`.
  - On a fault, AO carries the faulting address and no bus request is made.
- A memory access is issued only when all of these hold: `MEM_valid`, no incoming exception bit, no address error, and `cancel` low.
- The FSM has states IDLE, REQ, WAIT, DONE and DRAIN:
  - IDLE to REQ: an access is issued. Otherwise `MEM_over = MEM_valid` combinationally, and AO is the ALU result or BadVAddr.
  - REQ: `data_req = 1`. `data_addr`, `data_wr`, `data_size` and `data_wdata` are held stable. On `data_addr_ok` the FSM moves to WAIT.
  - WAIT: on `data_data_ok`, `data_rdata` is latched and the FSM moves to DONE.
  - DONE: `MEM_over = 1` and AO is the aligned load data (or the ALU result for stores). On `WB_allow_in` the FSM returns to IDLE.
  - DRAIN: the stage waits for the orphan `data_data_ok`, then returns to IDLE. Read data is discarded; `MEM_over = 0`.
- `cancel` behaviour by state:
  - REQ without `addr_ok`: go to IDLE.
  - REQ with `addr_ok`, or WAIT without `data_ok`: go to DRAIN.
  - WAIT with `data_ok`, or DONE: go to IDLE.
  - A store whose address has already been accepted is not revoked. The exception logic only cancels instructions younger than the faulting one.
- Load extension uses the byte lane selected by `addr[1:0]`:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Store data: SB sends `{4{rt[7:0]}}`, SH sends `{2{rt[15:0]}}`, SW sends `rt`.
- `MEM_allow_in = (IDLE & ~MEM_valid) | (MEM_over & WB_allow_in)`. It is low in REQ, WAIT and DRAIN.

## Timing
- Reset is asynchronous and sets state to IDLE.
- Reset values: `data_req = 0`, latched read data 0, `MEM_over = 0`, `MEM_allow_in = 1` (`MEM_valid` is 0 while upstream is in reset). `MEM_OUT`, `MEM_OUT_EXC` and `MEM_OUT_DELAY` are 0 because upstream presents zeros.
- Non-memory or excepting instruction: 0-cycle stage latency.
- Load or store latency: cycle 0 IDLE, cycle 1 REQ, then WAIT, then DONE. The minimum is `MEM_over` 3 cycles after the instruction arrives, assuming `addr_ok` in REQ and `data_ok` on the first WAIT cycle.
- DONE to IDLE inserts one bubble before the next access is issued.
- A `data_data_ok` seen outside WAIT and DRAIN is ignored.
- Reset during REQ, WAIT or DRAIN returns the FSM to IDLE immediately. The bus is assumed to be reset by the same signal.

## Structure
- Package `mips_mem_pkg` holds:
  - the load/store opcode constants;
  - the state enum;
  - the `MEM_IN`/`MEM_OUT` field offsets;
  - the exception bit indices.
- The FSM and bus handshake live in `mem_stage`.
- Sub-module `load_align` (combinational) takes `rdata`, `addr[1:0]` and opcode, and returns the aligned, extended 32-bit value.

## Test plan
- LW with `addr 0x100`, `addr_ok` on the first REQ cycle, `data_ok` next cycle with `rdata 0xDEADBEEF` -> `MEM_over` 3 cycles after arrival, AO = 0xDEADBEEF, EXC = 0.
- LB at `addr 0x103` with `rdata 0x80FFFFFF` -> AO = 0xFFFFFF80. LBU at the same address -> AO = 0x00000080.
- SH at `addr 0x201`:
  - `data_req` is never asserted;
  - `MEM_OUT_EXC[4] = 1`;
  - AO = 0x00000201;
  - `MEM_over` is asserted the same cycle the instruction arrives.
- SB at `0x302` with `rt = 0x12345678` -> `data_wdata = 0x78787878`, `data_size = 0`, `data_wr = 1`.
- `cancel` pulsed in WAIT -> FSM goes to DRAIN; `MEM_over` stays 0 through the late `data_ok`, then the FSM returns to IDLE with `MEM_allow_in = 1`.
- `WB_allow_in = 0` held for 4 cycles in DONE -> `MEM_OUT` is stable, `MEM_allow_in = 0`, and no new request is issued.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS32 memory-access stage.
// Holds the load/store opcodes, the stage FSM states, the pipeline bundle
// field offsets and the exception-vector bit positions.
package mips_mem_pkg;

    // Load/store opcodes (IR[31:26])
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Bus access sizes
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // MEM_IN / MEM_OUT field offsets (each field is 32 bits wide)
    localparam int IR_LSB  = 96;
    localparam int PC4_LSB = 64;
    localparam int AO_LSB  = 32;
    localparam int RT_LSB  = 0;
    localparam int LO_LSB  = 0;

    // Exception vector bit indices
    localparam int EXC_PC    = 6;
    localparam int EXC_LADDR = 5;
    localparam int EXC_SADDR = 4;
    localparam int EXC_SYS   = 3;
    localparam int EXC_BREAK = 2;
    localparam int EXC_RI    = 1;
    localparam int EXC_OV    = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } mem_state_e;

    function automatic logic op_is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed byte/half lane of a little-endian read
// word and sign- or zero-extends it according to the load opcode.
// Ports: rdata (raw word), addr_lo (addr[1:0]), opcode (IR[31:26]) -> result.
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [5:0]  opcode,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Halfword loads are aligned, so only addr[1] picks the lane
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (opcode)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'h0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS32 memory-access stage. Issues load/store requests on a
// req/addr_ok/data_ok SRAM bus, flags alignment faults, aligns load data.
// Ports: pipeline in (MEM_IN/LO/EXC/DELAY, MEM_valid, cancel), pipeline out
// (MEM_OUT/EXC/DELAY, MEM_over, MEM_allow_in, WB_allow_in), data_* SRAM bus.
module mem_stage
    import mips_mem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         cancel,
    input  logic         MEM_valid,
    input  logic [127:0] MEM_IN,
    input  logic [31:0]  MEM_IN_LO,
    input  logic [6:0]   MEM_IN_EXC,
    input  logic         MEM_IN_DELAY,
    input  logic         WB_allow_in,
    output logic         MEM_allow_in,
    output logic         MEM_over,
    output logic [127:0] MEM_OUT,
    output logic [6:0]   MEM_OUT_EXC,
    output logic         MEM_OUT_DELAY,
    output logic         data_req,
    output logic         data_wr,
    output logic [1:0]   data_size,
    output logic [31:0]  data_addr,
    output logic [31:0]  data_wdata,
    input  logic         data_addr_ok,
    input  logic         data_data_ok,
    input  logic [31:0]  data_rdata
);

    mem_state_e  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] ir, pc4, alu_res, rt_val;
    logic [5:0]  opcode;
    logic        is_load, is_store, is_mem;
    logic [1:0]  acc_size;
    logic        misalign, ld_err, st_err, addr_err;
    logic        issue;
    logic [31:0] load_val;
    logic [31:0] ao;

    assign ir      = MEM_IN[IR_LSB  +: 32];
    assign pc4     = MEM_IN[PC4_LSB +: 32];
    assign alu_res = MEM_IN[AO_LSB  +: 32];
    assign rt_val  = MEM_IN[RT_LSB  +: 32];
    assign opcode  = ir[31:26];

    // Decode, alignment check and store-data replication
    always_comb begin
        is_load  = op_is_load(opcode);
        is_store = op_is_store(opcode);
        is_mem   = is_load | is_store;

        case (opcode)
            OP_LB, OP_LBU, OP_SB: acc_size = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: acc_size = SIZE_HALF;
            default:              acc_size = SIZE_WORD;
        endcase

        misalign = ((acc_size == SIZE_WORD) && (alu_res[1:0] != 2'b00)) ||
                   ((acc_size == SIZE_HALF) && alu_res[0]);
        ld_err   = is_load  & misalign;
        st_err   = is_store & misalign;
        addr_err = ld_err | st_err;

        case (acc_size)
            SIZE_BYTE: data_wdata = {4{rt_val[7:0]}};
            SIZE_HALF: data_wdata = {2{rt_val[15:0]}};
            default:   data_wdata = rt_val;
        endcase
    end

    // Upstream exceptions and faults suppress the bus access entirely
    assign issue = MEM_valid & is_mem & ~(|MEM_IN_EXC) & ~addr_err & ~cancel;

    // Request fields come straight from MEM_IN: upstream is frozen while
    // MEM_allow_in is low, so they stay stable for the whole transaction.
    assign data_wr   = is_store;
    assign data_size = acc_size;
    assign data_addr = alu_res;

    load_align u_load_align (
        .rdata   (rdata_q),
        .addr_lo (alu_res[1:0]),
        .opcode  (opcode),
        .result  (load_val)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (issue) state_d = S_REQ;
            end
            S_REQ: begin
                // Once the address is accepted the bus owes us a data_ok,
                // so a cancel at that point must wait it out in DRAIN.
                if (data_addr_ok)  state_d = cancel ? S_DRAIN : S_WAIT;
                else if (cancel)   state_d = S_IDLE;
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    rdata_d = data_rdata;
                    state_d = cancel ? S_IDLE : S_DONE;
                end else if (cancel) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (cancel || WB_allow_in) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (data_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        data_req = 1'b0;
        MEM_over = 1'b0;
        ao       = alu_res;
        case (state_q)
            S_IDLE: MEM_over = MEM_valid & ~issue;
            S_REQ:  data_req = 1'b1;
            S_DONE: begin
                MEM_over = 1'b1;
                if (is_load) ao = load_val;
            end
            default: ;
        endcase
    end

    assign MEM_allow_in  = ((state_q == S_IDLE) & ~MEM_valid) | (MEM_over & WB_allow_in);
    assign MEM_OUT       = {ir, pc4, ao, MEM_IN_LO};
    assign MEM_OUT_EXC   = MEM_IN_EXC | {1'b0, ld_err, st_err, 4'b0000};
    assign MEM_OUT_DELAY = MEM_IN_DELAY;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mips_mem_pkg::*;

    localparam logic [31:0] PC4 = 32'h0040_0004;
    localparam logic [31:0] LO  = 32'hCAFE_F00D;

    logic         clk = 1'b0;
    logic         reset, cancel, MEM_valid, MEM_IN_DELAY, WB_allow_in;
    logic [127:0] MEM_IN;
    logic [31:0]  MEM_IN_LO;
    logic [6:0]   MEM_IN_EXC;
    logic         MEM_allow_in, MEM_over, MEM_OUT_DELAY;
    logic [127:0] MEM_OUT;
    logic [6:0]   MEM_OUT_EXC;
    logic         data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]   data_size;
    logic [31:0]  data_addr, data_wdata, data_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .cancel(cancel), .MEM_valid(MEM_valid),
        .MEM_IN(MEM_IN), .MEM_IN_LO(MEM_IN_LO), .MEM_IN_EXC(MEM_IN_EXC),
        .MEM_IN_DELAY(MEM_IN_DELAY), .WB_allow_in(WB_allow_in),
        .MEM_allow_in(MEM_allow_in), .MEM_over(MEM_over), .MEM_OUT(MEM_OUT),
        .MEM_OUT_EXC(MEM_OUT_EXC), .MEM_OUT_DELAY(MEM_OUT_DELAY),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [5:0] op, input logic [31:0] addr,
                                        input logic [31:0] rt);
        return {op, 26'h0, PC4, addr, rt};
    endfunction

    function automatic logic [127:0] out_of(input logic [5:0] op, input logic [31:0] ao);
        return {op, 26'h0, PC4, ao, LO};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // From IDLE with a valid access presented: addr_ok on the first REQ cycle,
    // data_ok on the first WAIT cycle, returns settled in DONE.
    task automatic run_access(input logic [31:0] rd);
        cyc();
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rd;
        cyc();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        #1;
    endtask

    initial begin
        reset = 1'b1; cancel = 1'b0; MEM_valid = 1'b0; MEM_IN = '0;
        MEM_IN_LO = LO; MEM_IN_EXC = '0; MEM_IN_DELAY = 1'b0; WB_allow_in = 1'b1;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;

        // Reset state
        cyc(); cyc();
        chk("rst_req",     128'(data_req), 128'(0));
        chk("rst_over",    128'(MEM_over), 128'(0));
        chk("rst_allow",   128'(MEM_allow_in), 128'(1));
        chk("rst_exc",     128'(MEM_OUT_EXC), 128'(0));
        chk("rst_out",     MEM_OUT, {64'h0, 32'h0, LO});
        reset = 1'b0;
        cyc();

        // Non-memory instruction: 0-cycle, pass-through
        MEM_valid = 1'b1; MEM_IN = mk(6'h00, 32'h0000_1234, 32'h0); MEM_IN_DELAY = 1'b1;
        #1;
        chk("alu_over",  128'(MEM_over), 128'(1));
        chk("alu_out",   MEM_OUT, out_of(6'h00, 32'h0000_1234));
        chk("alu_delay", 128'(MEM_OUT_DELAY), 128'(1));
        chk("alu_allow", 128'(MEM_allow_in), 128'(1));
        chk("alu_req",   128'(data_req), 128'(0));
        cyc();
        MEM_valid = 1'b0; MEM_IN_DELAY = 1'b0;

        // LW 0x100: MEM_over 3 cycles after arrival
        MEM_valid = 1'b1; MEM_IN = mk(OP_LW, 32'h100, 32'h0);
        #1;
        chk("lw_c0_over",  128'(MEM_over), 128'(0));
        chk("lw_c0_allow", 128'(MEM_allow_in), 128'(0));
        cyc();
        chk("lw_c1_req",  128'(data_req), 128'(1));
        chk("lw_c1_addr", 128'(data_addr), 128'(32'h100));
        chk("lw_c1_size", 128'(data_size), 128'(2));
        chk("lw_c1_wr",   128'(data_wr), 128'(0));
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        chk("lw_c2_req",  128'(data_req), 128'(0));
        chk("lw_c2_over", 128'(MEM_over), 128'(0));
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        cyc();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        chk("lw_c3_over",  128'(MEM_over), 128'(1));
        chk("lw_c3_out",   MEM_OUT, out_of(OP_LW, 32'hDEAD_BEEF));
        chk("lw_c3_exc",   128'(MEM_OUT_EXC), 128'(0));
        chk("lw_c3_allow", 128'(MEM_allow_in), 128'(1));
        cyc();
        MEM_valid = 1'b0;

        // LB / LBU / LH byte-lane extraction
        MEM_valid = 1'b1; MEM_IN = mk(OP_LB, 32'h103, 32'h0);
        run_access(32'h80FF_FFFF);
        chk("lb_ao", 128'(MEM_OUT[AO_LSB +: 32]), 128'(32'hFFFF_FF80));
        cyc();
        MEM_IN = mk(OP_LBU, 32'h103, 32'h0);
        run_access(32'h80FF_FFFF);
        chk("lbu_ao", 128'(MEM_OUT[AO_LSB +: 32]), 128'(32'h0000_0080));
        cyc();
        MEM_IN = mk(OP_LH, 32'h102, 32'h0);
        run_access(32'h80FF_1234);
        chk("lh_ao", 128'(MEM_OUT[AO_LSB +: 32]), 128'(32'hFFFF_80FF));
        cyc();
        MEM_IN = mk(OP_LHU, 32'h100, 32'h0);
        run_access(32'h1234_ABCD);
        chk("lhu_ao", 128'(MEM_OUT[AO_LSB +: 32]), 128'(32'h0000_ABCD));
        cyc();
        MEM_valid = 1'b0;

        // SH at 0x201: store address error, no request, same-cycle MEM_over
        MEM_valid = 1'b1; MEM_IN = mk(OP_SH, 32'h201, 32'h5555_AAAA);
        #1;
        chk("sh_over", 128'(MEM_over), 128'(1));
        chk("sh_exc",  128'(MEM_OUT_EXC), 128'(7'h10));
        chk("sh_ao",   128'(MEM_OUT[AO_LSB +: 32]), 128'(32'h0000_0201));
        chk("sh_req0", 128'(data_req), 128'(0));
        WB_allow_in = 1'b0;
        cyc();
        chk("sh_req1", 128'(data_req), 128'(0));
        WB_allow_in = 1'b1;
        cyc();

        // LW at 0x102: load address error ORed with upstream overflow bit
        MEM_IN = mk(OP_LW, 32'h102, 32'h0); MEM_IN_EXC = 7'h01;
        #1;
        chk("lwe_exc",  128'(MEM_OUT_EXC), 128'(7'h21));
        chk("lwe_over", 128'(MEM_over), 128'(1));
        // Aligned LW with only an upstream exception: still no access
        MEM_IN = mk(OP_LW, 32'h100, 32'h0);
        cyc();
        chk("lwx_req",  128'(data_req), 128'(0));
        chk("lwx_exc",  128'(MEM_OUT_EXC), 128'(7'h01));
        MEM_IN_EXC = '0;
        MEM_valid = 1'b0;
        cyc();

        // SB at 0x302: replicated data, request held until addr_ok
        MEM_valid = 1'b1; MEM_IN = mk(OP_SB, 32'h302, 32'h1234_5678);
        cyc();
        chk("sb_wdata", 128'(data_wdata), 128'(32'h7878_7878));
        chk("sb_size",  128'(data_size), 128'(0));
        chk("sb_wr",    128'(data_wr), 128'(1));
        chk("sb_req",   128'(data_req), 128'(1));
        cyc();
        chk("sb_req_hold",  128'(data_req), 128'(1));
        chk("sb_addr_hold", 128'(data_addr), 128'(32'h302));
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        cyc();
        data_data_ok = 1'b0;
        #1;
        chk("sb_done_over", 128'(MEM_over), 128'(1));
        chk("sb_done_ao",   128'(MEM_OUT[AO_LSB +: 32]), 128'(32'h302));
        cyc();
        MEM_valid = 1'b0;

        // Cancel in WAIT -> DRAIN until the orphan data_ok
        MEM_valid = 1'b1; MEM_IN = mk(OP_LW, 32'h100, 32'h0);
        cyc();
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0; cancel = 1'b1; MEM_valid = 1'b0;
        cyc();
        cancel = 1'b0;
        #1;
        chk("drain_over",  128'(MEM_over), 128'(0));
        chk("drain_allow", 128'(MEM_allow_in), 128'(0));
        chk("drain_req",   128'(data_req), 128'(0));
        cyc();
        data_data_ok = 1'b1; data_rdata = 32'h5A5A_5A5A;
        #1;
        chk("drain_ok_over", 128'(MEM_over), 128'(0));
        cyc();
        data_data_ok = 1'b0;
        #1;
        chk("drain_idle_allow", 128'(MEM_allow_in), 128'(1));
        chk("drain_idle_over",  128'(MEM_over), 128'(0));

        // Stray data_ok in IDLE is ignored
        data_data_ok = 1'b1;
        cyc();
        data_data_ok = 1'b0;
        #1;
        chk("stray_allow", 128'(MEM_allow_in), 128'(1));
        chk("stray_req",   128'(data_req), 128'(0));

        // WB stall for 4 cycles in DONE
        MEM_valid = 1'b1; MEM_IN = mk(OP_LW, 32'h104, 32'h0); WB_allow_in = 1'b0;
        run_access(32'h1122_3344);
        for (int i = 0; i < 4; i++) begin
            chk("stall_out",   MEM_OUT, out_of(OP_LW, 32'h1122_3344));
            chk("stall_over",  128'(MEM_over), 128'(1));
            chk("stall_allow", 128'(MEM_allow_in), 128'(0));
            chk("stall_req",   128'(data_req), 128'(0));
            cyc();
        end
        WB_allow_in = 1'b1;
        #1;
        chk("stall_release", 128'(MEM_allow_in), 128'(1));
        cyc();
        MEM_valid = 1'b0;
        #1;
        chk("stall_idle_over", 128'(MEM_over), 128'(0));

        // Reset asserted during REQ drops the request immediately
        MEM_valid = 1'b1; MEM_IN = mk(OP_LW, 32'h100, 32'h0);
        cyc();
        chk("rreq_req", 128'(data_req), 128'(1));
        reset = 1'b1; MEM_valid = 1'b0;
        #1;
        chk("rreq_req_rst", 128'(data_req), 128'(0));
        chk("rreq_allow",   128'(MEM_allow_in), 128'(1));
        cyc();
        reset = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
